sdram_rd_arbiter: RTL and testbench
===================================

Name: sdram_rd_arbiter

Overview:
- Shares the single SDRAM read port between two requesters: the VGA display reader (port 0) and the image resizer capture path (port 1).
- Each requester asks for a burst of consecutive words. The arbiter grants whole bursts, issues one read command per accepted cycle, and tags every command.
- Returned data is routed back to the requester that issued the command, in issue order.
- Sits between the requesters and the SDRAM controller read interface.

Parameters:
- ADDR_W, 23, SDRAM word address width.
- DATA_W, 16, SDRAM read data width.
- LEN_W, 9, burst length field width; legal lengths are 1..256.
- MAX_OUT, 8, maximum in-flight read commands; must be a power of 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  display burst request; held until grant0
- addr0  in  ADDR_W  display burst start address
- len0  in  LEN_W  display burst length
- req1  in  1  resizer burst request; held until grant1
- addr1  in  ADDR_W  resizer burst start address
- len1  in  LEN_W  resizer burst length
- grant0, grant1  out  1  one-cycle pulse when the burst is accepted
- data_out  out  DATA_W  routed read data, shared by both ports
- valid0, valid1  out  1  data_out is valid for port 0 / port 1
- done0, done1  out  1  one-cycle pulse together with the last word of a burst
- cmd_valid  out  1  read command to SDRAM controller
- cmd_addr  out  ADDR_W  read command address
- cmd_ready  in  1  controller accepts the command this cycle
- rd_valid  in  1  read data returned, in command order
- rd_data  in  DATA_W  returned data
- busy  out  1  burst active or reads in flight

Behaviour:
Reset (asynchronous, effective immediately):
- All outputs are 0.
- State is S_IDLE, last_owner is 1, tag FIFO is empty, counters are 0.

State S_IDLE:
- If exactly one req is high, that port wins.
- If both are high, the port other than last_owner wins (round-robin). After reset, port 0 wins the first tie.
- On a win, the cycle after the decision:
  - pulse grant for the winner;
  - latch the winner's addr into cur_addr and its len into remaining (len 0 is treated as 1);
  - set owner and last_owner to the winner;
  - go to S_BURST.
- Latency from req high in idle to grant high is 1 cycle.

State S_BURST:
- cmd_valid = 1 when the FIFO is not full (occupancy < MAX_OUT); cmd_addr = cur_addr.
- On cmd_valid && cmd_ready:
  - push {owner, last = (remaining == 1)} into the FIFO;
  - cur_addr increments, wrapping modulo 2^ADDR_W;
  - remaining decrements.
- When the last command is accepted, go to S_IDLE. Arbitration for the next burst happens in that idle cycle, so there is 1 dead command cycle between bursts.
- cmd_valid and cmd_addr stay stable while cmd_ready is low.

Return path (independent of state):
- On rd_valid, pop the FIFO head.
- In the same cycle (combinational routing): data_out = rd_data, and valid[id] = 1.
- If head.last = 1, done[id] = 1 in the same cycle.
- rd_valid with an empty FIFO is a protocol error: ignored, no valid output, FIFO unchanged.
- A simultaneous push and pop keeps occupancy unchanged. A pop frees a slot, but cmd_valid only sees it from the next cycle.

Other rules:
- busy = (state != S_IDLE) || FIFO not empty.
- A requester dropping req before its grant is legal and cancels the request. req is not sampled during S_BURST.
- Reset mid-burst or with reads in flight flushes everything. Data returned after reset is ignored because the FIFO is empty.

Test Plan:
- Single request: req1 with addr1=0x000100, len1=4, cmd_ready=1, data returned 2 cycles after each command.
  -> grant1 at cycle 1; cmd_addr 0x100..0x103 on consecutive cycles; 4 valid1 pulses; done1 with the 4th; valid0 never asserts.
- Contention: req0 and req1 both high after reset, len=2 each.
  -> port 0 granted first; port 1 granted in the idle cycle after port 0's last command; the next tie goes to port 0 again.
- Backpressure: MAX_OUT=8, len=16, no rd_valid.
  -> exactly 8 commands accepted, then cmd_valid=0; each later rd_valid lets exactly 1 more command issue.
- Interleaved return: port 0 burst of 3 then port 1 burst of 2, data returned late.
  -> valid0 x3 (done0 on the 3rd) then valid1 x2 (done1 on the 2nd), in strict order.
- Boundaries: addr0=0x7FFFFE, len0=4 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001. len0=0 -> exactly 1 command.
- Reset mid-burst: assert rst after 2 of 8 commands.
  -> all outputs 0 at once; busy=0; a stray rd_valid afterwards produces no valid or done.

Source files
------------

// File: rtl/sdram_rd_arbiter.sv
// Two-port burst read arbiter in front of an SDRAM controller read port.
// Grants whole bursts round-robin, tags each command, routes returned data by tag.
module sdram_rd_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 9,
    parameter int MAX_OUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [LEN_W-1:0]  len0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len1,
    output logic              grant0,
    output logic              grant1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid0,
    output logic              valid1,
    output logic              done0,
    output logic              done1,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ready,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy
);
    // Handshakes: a command transfers on any cycle with cmd_valid && cmd_ready, and
    // cmd_valid/cmd_addr hold until it does. rd_valid has no back-pressure; every
    // beat consumes one tag from the head of the tag FIFO (ignored when empty).

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUT);

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic              grant0_q, grant0_d;
    logic              grant1_q, grant1_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [1:0]        fifo_mem_q [MAX_OUT];  // {owner, last}

    logic              win0, win1;
    logic [LEN_W-1:0]  sel_len;
    logic              push, pop;
    logic [1:0]        head;

    assign cmd_valid = (state_q == S_BURST) && (count_q != FULL_CNT);
    assign cmd_addr  = cur_addr_q;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = rd_valid && (count_q != '0);
    assign head      = fifo_mem_q[rd_ptr_q];

    assign grant0   = grant0_q;
    assign grant1   = grant1_q;
    assign data_out = pop ? rd_data : '0;
    assign valid0   = pop && !head[1];
    assign valid1   = pop && head[1];
    assign done0    = pop && !head[1] && head[0];
    assign done1    = pop && head[1] && head[0];
    assign busy     = (state_q != S_IDLE) || (count_q != '0);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        grant0_d     = 1'b0;
        grant1_d     = 1'b0;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        // On a tie the port that did not own the previous burst wins.
        win0    = req0 && (!req1 || last_owner_q);
        win1    = req1 && (!req0 || !last_owner_q);
        sel_len = win1 ? len1 : len0;

        unique case (state_q)
            S_IDLE: begin
                if (win0 || win1) begin
                    grant0_d     = win0;
                    grant1_d     = win1;
                    owner_d      = win1;
                    last_owner_d = win1;
                    cur_addr_d   = win1 ? addr1 : addr0;
                    remaining_d  = (sel_len == '0) ? LEN_W'(1) : sel_len;
                    state_d      = S_BURST;
                end
            end
            S_BURST: begin
                if (push) begin
                    cur_addr_d  = cur_addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            grant0_q     <= 1'b0;
            grant1_q     <= 1'b0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < MAX_OUT; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            grant0_q     <= grant0_d;
            grant1_q     <= grant1_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (push) fifo_mem_q[wr_ptr_q] <= {owner_q, remaining_q == LEN_W'(1)};
        end
    end
endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Bench for sdram_rd_arbiter: requester drivers, a command/return responder and a
// scoreboard of expected commands and routed return beats.
module tb_sdram_rd_arbiter;
    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 16;
    localparam int LEN_W   = 9;
    localparam int MAX_OUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [LEN_W-1:0]  len0 = '0, len1 = '0;
    logic              grant0, grant1, valid0, valid1, done0, done1;
    logic [DATA_W-1:0] data_out;
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ready = 1'b0;
    logic              rd_valid = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              busy;

    sdram_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .len0(len0),
        .req1(req1), .addr1(addr1), .len1(len1),
        .grant0(grant0), .grant1(grant1),
        .data_out(data_out), .valid0(valid0), .valid1(valid1),
        .done0(done0), .done1(done1),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard state: {owner, last, addr} per expected command, {owner, last} per
    // accepted command awaiting data, and expected {grant1, grant0} pulses.
    logic [ADDR_W+1:0] exp_q[$];
    logic [1:0]        inflight_q[$];
    logic [1:0]        exp_grant_q[$];
    int                due_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int ret_req = 0;
    int ret_done = 0;
    bit auto_ret = 1'b1;
    int ret_lat = 2;
    bit rand_ready = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_burst(input logic owner, input logic [ADDR_W-1:0] addr,
                                input logic [LEN_W-1:0] len);
        int n;
        logic [ADDR_W-1:0] a;
        n = (len == '0) ? 1 : int'(len);
        a = addr;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({owner, i == n - 1, a});
            a = a + 1'b1;
        end
        exp_grant_q.push_back(owner ? 2'b10 : 2'b01);
    endtask

    // Raise req, hold until the grant pulse, then drop. lat = cycles from req to grant.
    task automatic req_burst(input logic port, input logic [ADDR_W-1:0] addr,
                             input logic [LEN_W-1:0] len, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        @(posedge clk);
        #1;
        if (port) begin req1 = 1'b1; addr1 = addr; len1 = len; end
        else      begin req0 = 1'b1; addr0 = addr; len0 = len; end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (port ? grant1 : grant0) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        if (!got) chk_eq("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #2;
            if (!busy && exp_q.size() == 0 && inflight_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("idle_reached", 32'(ok), 1);
        chk_eq("cmds_left", exp_q.size(), 0);
        chk_eq("grants_left", exp_grant_q.size(), 0);
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Responder and monitor: drives cmd_ready/rd_valid after each posedge and checks
    // every DUT output at the following negedge.
    initial begin : responder
        bit                hold_pend;
        logic [ADDR_W-1:0] hold_addr;
        logic [ADDR_W+1:0] e;
        logic [1:0]        p;
        hold_pend = 1'b0;
        hold_addr = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            rd_valid  = 1'b0;
            rd_data   = '0;
            cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ret_req > ret_done) begin
                rd_valid = 1'b1;
                rd_data  = DATA_W'($urandom);
                ret_done++;
            end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
                rd_valid = 1'b1;
                rd_data  = DATA_W'($urandom);
                void'(due_q.pop_front());
            end
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                inflight_q.delete();
                exp_grant_q.delete();
                due_q.delete();
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) chk_eq("cmd_hold", {cmd_valid, cmd_addr}, {1'b1, hold_addr});
                hold_pend = cmd_valid && !cmd_ready;
                hold_addr = cmd_addr;
                if (grant0 || grant1) begin
                    if (exp_grant_q.size() == 0) chk_eq("grant_extra", {grant1, grant0}, 0);
                    else chk_eq("grant", {grant1, grant0}, exp_grant_q.pop_front());
                end
                if (cmd_valid && cmd_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        chk_eq("cmd_extra", cmd_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk_eq("cmd_addr", cmd_addr, e[ADDR_W-1:0]);
                        inflight_q.push_back(e[ADDR_W+1:ADDR_W]);
                        if (auto_ret) due_q.push_back(cyc + ret_lat);
                    end
                end
                if (rd_valid && inflight_q.size() != 0) begin
                    p = inflight_q.pop_front();
                    chk_eq("rd_data", data_out, rd_data);
                    chk_eq("route", {valid1, valid0, done1, done0},
                           {p[1], !p[1], p[1] && p[0], !p[1] && p[0]});
                end else begin
                    chk_eq("no_return", {valid1, valid0, done1, done0}, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat_a, lat_b, base;

        #3;
        chk_eq("rst_outputs", {grant0, grant1, valid0, valid1, done0, done1, cmd_valid, busy}, 0);
        chk_eq("rst_cmd_addr", cmd_addr, 0);
        chk_eq("rst_data_out", data_out, 0);
        wait_cycles(2);
        @(posedge clk);
        #3 rst = 1'b0;

        // Ties: port 0 wins the first tie after reset, port 1 follows after one dead cycle.
        auto_ret = 1'b1; ret_lat = 2; rand_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            expect_burst(1'b0, ADDR_W'(32'h1000 + r * 16), 2);
            expect_burst(1'b1, ADDR_W'(32'h2000 + r * 16), 2);
            fork
                req_burst(1'b0, ADDR_W'(32'h1000 + r * 16), 2, lat_a);
                req_burst(1'b1, ADDR_W'(32'h2000 + r * 16), 2, lat_b);
            join
            chk_eq("tie_lat0", lat_a, 1);
            chk_eq("tie_lat1", lat_b, 4);
            wait_idle(60);
        end

        // Interleaved late return with a randomly stalling controller.
        auto_ret = 1'b1; ret_lat = 6; rand_ready = 1'b1;
        expect_burst(1'b0, 23'h000300, 3);
        expect_burst(1'b1, 23'h000400, 2);
        fork
            req_burst(1'b0, 23'h000300, 3, lat_a);
            req_burst(1'b1, 23'h000400, 2, lat_b);
        join
        wait_idle(200);

        // Single request from the resizer port.
        auto_ret = 1'b1; ret_lat = 2; rand_ready = 1'b0;
        expect_burst(1'b1, 23'h000100, 4);
        req_burst(1'b1, 23'h000100, 4, lat_a);
        chk_eq("grant_lat", lat_a, 1);
        wait_idle(60);

        // Back-pressure from a full tag FIFO.
        auto_ret = 1'b0; rand_ready = 1'b0;
        base = acc_cnt;
        expect_burst(1'b0, 23'h000200, 16);
        req_burst(1'b0, 23'h000200, 16, lat_a);
        wait_cycles(20);
        #2;
        chk_eq("bp_first", acc_cnt - base, MAX_OUT);
        chk_eq("bp_stall", cmd_valid, 0);
        for (int i = 0; i < 8; i++) begin
            ret_req++;
            wait_cycles(4);
            #2;
            chk_eq("bp_step", acc_cnt - base, MAX_OUT + 1 + i);
        end
        ret_req += 8;
        wait_idle(60);

        // Address wrap and zero length.
        auto_ret = 1'b1; ret_lat = 3;
        expect_burst(1'b0, 23'h7FFFFE, 4);
        req_burst(1'b0, 23'h7FFFFE, 4, lat_a);
        wait_idle(60);
        base = acc_cnt;
        expect_burst(1'b0, 23'h000123, 0);
        req_burst(1'b0, 23'h000123, 0, lat_a);
        wait_idle(60);
        chk_eq("len0_cmds", acc_cnt - base, 1);

        // Reset in the middle of a burst.
        auto_ret = 1'b0;
        base = acc_cnt;
        expect_burst(1'b1, 23'h000500, 8);
        req_burst(1'b1, 23'h000500, 8, lat_a);
        for (int k = 0; k < 50 && (acc_cnt - base) < 2; k++) begin
            @(negedge clk);
            #2;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_eq("midrst_outputs", {grant0, grant1, valid0, valid1, done0, done1, cmd_valid, busy}, 0);
        chk_eq("midrst_cmd_addr", cmd_addr, 0);
        wait_cycles(2);
        @(posedge clk);
        #3 rst = 1'b0;
        ret_req++;
        wait_cycles(4);
        #2;
        chk_eq("post_rst_busy", busy, 0);
        chk_eq("post_rst_cmd", cmd_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
